// File: rtl/fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fp_wb_arbiter
// Brief    : FP writeback arbiter (FPU/LSU round-robin), result FIFO and
//            per-register pending scoreboard for RAW/WAW hazard detection.
// Revision : 1.0
// ============================================================================
module fp_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int NREG  = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        issue_valid_i,
    input  logic [4:0]  issue_frd_i,
    input  logic        fpu_valid_i,
    input  logic [4:0]  fpu_rd_i,
    input  logic [31:0] fpu_data_i,
    output logic        fpu_ready_o,
    input  logic        lsu_valid_i,
    input  logic [4:0]  lsu_rd_i,
    input  logic [31:0] lsu_data_i,
    output logic        lsu_ready_o,
    input  logic        wb_stall_i,
    input  logic [4:0]  query_rs1_i,
    input  logic [4:0]  query_rs2_i,
    input  logic [4:0]  query_rs3_i,
    input  logic [4:0]  query_rd_i,
    output logic        hazard_o,
    output logic        fregwrite_o,
    output logic [4:0]  frd_o,
    output logic [31:0] writeback_data_o,
    output logic        fifo_full_o
);

    localparam int c_ptr_w   = $clog2(DEPTH);
    localparam int c_cnt_w   = c_ptr_w + 1;
    localparam int c_entry_w = 5 + 32;

    typedef enum logic {
        SRC_FPU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

    logic [c_entry_w-1:0] r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    src_e                 r_last_grant;
    logic [NREG-1:0]      r_pending;
    logic                 r_fregwrite;
    logic [4:0]           r_frd;
    logic [31:0]          r_wb_data;

    logic                 w_space;
    logic                 w_grant_fpu;
    logic                 w_grant_lsu;
    logic                 w_push;
    logic                 w_pop;
    logic [c_entry_w-1:0] w_push_entry;
    logic [NREG-1:0]      w_set_vec;
    logic [NREG-1:0]      w_clr_vec;
    logic                 w_hazard;

    // Round-robin only matters under contention; a lone requester always wins.
    always_comb begin
        w_space     = (r_count < c_cnt_w'(DEPTH)) && !flush_i;
        w_grant_fpu = 1'b0;
        w_grant_lsu = 1'b0;
        if (w_space) begin
            if (fpu_valid_i && lsu_valid_i) begin
                w_grant_fpu = (r_last_grant == SRC_LSU);
                w_grant_lsu = (r_last_grant == SRC_FPU);
            end else begin
                w_grant_fpu = fpu_valid_i;
                w_grant_lsu = lsu_valid_i;
            end
        end
    end

    assign w_push       = w_grant_fpu | w_grant_lsu;
    assign w_push_entry = w_grant_lsu ? {lsu_rd_i, lsu_data_i} : {fpu_rd_i, fpu_data_i};
    assign w_pop        = (r_count != '0) && !wb_stall_i && !flush_i;

    // Readies are forced low while reset is held so no source sees a bogus accept.
    assign fpu_ready_o = w_grant_fpu & rst_ni;
    assign lsu_ready_o = w_grant_lsu & rst_ni;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_push_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_grant <= SRC_FPU;
        end else if (w_grant_fpu) begin
            r_last_grant <= SRC_FPU;
        end else if (w_grant_lsu) begin
            r_last_grant <= SRC_LSU;
        end
    end

    // Write-port registers hold their last value when no pop happens.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_fregwrite <= 1'b0;
            r_frd       <= '0;
            r_wb_data   <= '0;
        end else begin
            r_fregwrite <= w_pop;
            if (w_pop) begin
                {r_frd, r_wb_data} <= r_mem[r_rd_ptr];
            end
        end
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_pending
        assign w_set_vec[gi] = issue_valid_i && (issue_frd_i == 5'(gi));
        assign w_clr_vec[gi] = r_fregwrite && (r_frd == 5'(gi));
    end

    // A new issue to a register being written this cycle keeps it pending.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else if (flush_i) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr_vec) | w_set_vec;
        end
    end

    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (r_pending[i] && ((query_rs1_i == 5'(i)) || (query_rs2_i == 5'(i)) ||
                                 (query_rs3_i == 5'(i)) || (query_rd_i  == 5'(i)))) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign hazard_o         = w_hazard;
    assign fregwrite_o      = r_fregwrite;
    assign frd_o            = r_frd;
    assign writeback_data_o = r_wb_data;
    assign fifo_full_o      = (r_count == c_cnt_w'(DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_fp_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fp_wb_arbiter
// Brief    : Scoreboard bench for fp_wb_arbiter: directed scenarios followed
//            by randomized traffic against a queue-based reference model.
// Revision : 1.0
// ============================================================================
module tb_fp_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int NREG  = 32;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        flush_i;
    logic        issue_valid_i;
    logic [4:0]  issue_frd_i;
    logic        fpu_valid_i;
    logic [4:0]  fpu_rd_i;
    logic [31:0] fpu_data_i;
    logic        fpu_ready_o;
    logic        lsu_valid_i;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        lsu_ready_o;
    logic        wb_stall_i;
    logic [4:0]  query_rs1_i;
    logic [4:0]  query_rs2_i;
    logic [4:0]  query_rs3_i;
    logic [4:0]  query_rd_i;
    logic        hazard_o;
    logic        fregwrite_o;
    logic [4:0]  frd_o;
    logic [31:0] writeback_data_o;
    logic        fifo_full_o;

    always #5 clk_i = ~clk_i;

    fp_wb_arbiter #(.DEPTH(DEPTH), .NREG(NREG)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
        .issue_valid_i(issue_valid_i), .issue_frd_i(issue_frd_i),
        .fpu_valid_i(fpu_valid_i), .fpu_rd_i(fpu_rd_i), .fpu_data_i(fpu_data_i),
        .fpu_ready_o(fpu_ready_o),
        .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
        .lsu_ready_o(lsu_ready_o),
        .wb_stall_i(wb_stall_i),
        .query_rs1_i(query_rs1_i), .query_rs2_i(query_rs2_i),
        .query_rs3_i(query_rs3_i), .query_rd_i(query_rd_i),
        .hazard_o(hazard_o), .fregwrite_o(fregwrite_o), .frd_o(frd_o),
        .writeback_data_o(writeback_data_o), .fifo_full_o(fifo_full_o)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    // Reference model: buffered results, expected writes, pending set, last winner.
    wr_t         exp_q[$];
    logic [36:0] m_fifo[$];
    logic [NREG-1:0] m_pending;
    bit          m_last_lsu;
    bit          m_wr_valid;
    logic [4:0]  m_wr_rd;
    bit          g_f;
    bit          g_l;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write the DUT presents is matched against the next expected one.
    always @(negedge clk_i) begin
        if (rst_ni === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missing_write: rd=%0d due cycle %0d not seen by cycle %0d",
                         exp_q[0].rd, exp_q[0].due, cyc);
                void'(exp_q.pop_front());
            end
            if (fregwrite_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL spurious_write: got rd=%0d data=0x%0h, expected no write",
                             frd_o, writeback_data_o);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("wr_cycle", 64'(cyc), 64'(e.due));
                    chk("wr_rd", frd_o, e.rd);
                    chk("wr_data", writeback_data_o, e.data);
                end
            end
        end
    end

    task automatic clear_model();
        exp_q.delete();
        m_fifo.delete();
        m_pending  = '0;
        m_last_lsu = 1'b0;
        m_wr_valid = 1'b0;
        m_wr_rd    = '0;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        issue_valid_i = 1'b0;
        issue_frd_i   = '0;
        fpu_valid_i   = 1'b0;
        fpu_rd_i      = '0;
        fpu_data_i    = '0;
        lsu_valid_i   = 1'b0;
        lsu_rd_i      = '0;
        lsu_data_i    = '0;
        wb_stall_i    = 1'b0;
    endtask

    task automatic set_q(input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] c, input logic [4:0] d);
        query_rs1_i = a;
        query_rs2_i = b;
        query_rs3_i = c;
        query_rd_i  = d;
    endtask

    // Called right after a falling edge with inputs driven; checks, models, advances.
    task automatic step();
        bit          space;
        bit          pop;
        bit          exp_h;
        logic [36:0] e;
        wr_t         w;
        #1;
        space = (m_fifo.size() < DEPTH) && !flush_i;
        g_f = 1'b0;
        g_l = 1'b0;
        if (space) begin
            if (fpu_valid_i && lsu_valid_i) begin
                g_f = m_last_lsu;
                g_l = !m_last_lsu;
            end else begin
                g_f = fpu_valid_i;
                g_l = lsu_valid_i;
            end
        end
        exp_h = m_pending[query_rs1_i] | m_pending[query_rs2_i] |
                m_pending[query_rs3_i] | m_pending[query_rd_i];
        chk("fpu_ready", fpu_ready_o, g_f);
        chk("lsu_ready", lsu_ready_o, g_l);
        chk("fifo_full", fifo_full_o, m_fifo.size() == DEPTH);
        chk("hazard", hazard_o, exp_h);

        pop = (m_fifo.size() > 0) && !wb_stall_i && !flush_i;
        if (m_wr_valid) m_pending[m_wr_rd] = 1'b0;
        if (issue_valid_i) m_pending[issue_frd_i] = 1'b1;
        if (flush_i) m_pending = '0;
        m_wr_valid = pop;
        if (pop) begin
            e       = m_fifo.pop_front();
            m_wr_rd = e[36:32];
            w.due   = cyc + 1;
            w.rd    = e[36:32];
            w.data  = e[31:0];
            exp_q.push_back(w);
        end
        if (g_f) begin
            m_fifo.push_back({fpu_rd_i, fpu_data_i});
            m_last_lsu = 1'b0;
        end
        if (g_l) begin
            m_fifo.push_back({lsu_rd_i, lsu_data_i});
            m_last_lsu = 1'b1;
        end
        if (flush_i) m_fifo.delete();
        @(negedge clk_i);
    endtask

    // Reset asserted between edges: outputs must drop immediately.
    task automatic reset_checks();
        fpu_valid_i = 1'b1;
        lsu_valid_i = 1'b1;
        #1;
        chk("rst_fregwrite", fregwrite_o, 1'b0);
        chk("rst_frd", frd_o, 5'd0);
        chk("rst_data", writeback_data_o, 32'd0);
        chk("rst_fpu_ready", fpu_ready_o, 1'b0);
        chk("rst_lsu_ready", lsu_ready_o, 1'b0);
        chk("rst_full", fifo_full_o, 1'b0);
        chk("rst_hazard", hazard_o, 1'b0);
        clear_model();
        idle_inputs();
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    initial begin
        rst_ni = 1'b0;
        idle_inputs();
        set_q(5'd0, 5'd1, 5'd2, 5'd3);
        clear_model();
        @(negedge clk_i);
        reset_checks();

        // Single FPU result to f5.
        set_q(5'd5, 5'd5, 5'd5, 5'd5);
        issue_valid_i = 1'b1; issue_frd_i = 5'd5;
        step();
        issue_valid_i = 1'b0;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd5; fpu_data_i = 32'h3F80_0000;
        step();
        fpu_valid_i = 1'b0;
        repeat (4) step();

        // LSU wins once, so the following contention goes to the FPU first.
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd9; lsu_data_i = 32'h1234_5678;
        step();
        lsu_valid_i = 1'b0;
        step();
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd1; fpu_data_i = 32'h4000_0000;
        lsu_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 32'h4040_0000;
        for (int k = 0; k < 4; k++) begin
            step();
            if (g_f) fpu_valid_i = 1'b0;
            if (g_l) lsu_valid_i = 1'b0;
        end
        chk("contention_done", {fpu_valid_i, lsu_valid_i}, 2'b00);
        repeat (3) step();

        // Fill the FIFO under stall, then one more attempt.
        wb_stall_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fpu_valid_i = 1'b1; fpu_rd_i = 5'(10 + k); fpu_data_i = $urandom;
            step();
        end
        chk("full_after_4", fifo_full_o, 1'b1);
        wb_stall_i = 1'b0;
        for (int k = 0; k < 8 && fpu_valid_i; k++) begin
            step();
            if (g_f) fpu_valid_i = 1'b0;
        end
        chk("fifth_accepted", fpu_valid_i, 1'b0);
        repeat (7) step();

        // f7 re-issued in the very cycle its previous result is written.
        set_q(5'd7, 5'd7, 5'd7, 5'd7);
        issue_valid_i = 1'b1; issue_frd_i = 5'd7;
        step();
        issue_valid_i = 1'b0;
        fpu_valid_i = 1'b1; fpu_rd_i = 5'd7; fpu_data_i = 32'hC0A0_0000;
        step();
        fpu_valid_i = 1'b0;
        step();
        chk("f7_write_now", {fregwrite_o, frd_o}, {1'b1, 5'd7});
        issue_valid_i = 1'b1; issue_frd_i = 5'd7;
        step();
        issue_valid_i = 1'b0;
        step();
        chk("f7_still_pending", hazard_o, 1'b1);

        // Flush with three buffered results and f3/f4 pending.
        set_q(5'd3, 5'd4, 5'd0, 5'd0);
        issue_valid_i = 1'b1; issue_frd_i = 5'd3;
        step();
        issue_frd_i = 5'd4;
        step();
        issue_valid_i = 1'b0;
        wb_stall_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            fpu_valid_i = 1'b1; fpu_rd_i = 5'(20 + k); fpu_data_i = $urandom;
            step();
        end
        flush_i = 1'b1; issue_valid_i = 1'b1; issue_frd_i = 5'd3;
        step();
        flush_i = 1'b0; issue_valid_i = 1'b0; fpu_valid_i = 1'b0; wb_stall_i = 1'b0;
        chk("flush_hazard", hazard_o, 1'b0);
        repeat (4) step();

        // Async reset in the middle of a stream of LSU results.
        set_q(5'd0, 5'd1, 5'd2, 5'd3);
        for (int k = 0; k < 4; k++) begin
            lsu_valid_i = 1'b1; lsu_rd_i = 5'(k); lsu_data_i = $urandom;
            step();
        end
        #3;
        rst_ni = 1'b0;
        reset_checks();
        repeat (3) step();

        // Randomized traffic.
        for (int c = 0; c < 2000; c++) begin
            if (!fpu_valid_i && $urandom_range(0, 99) < 60) begin
                fpu_valid_i = 1'b1; fpu_rd_i = 5'($urandom); fpu_data_i = $urandom;
            end
            if (!lsu_valid_i && $urandom_range(0, 99) < 50) begin
                lsu_valid_i = 1'b1; lsu_rd_i = 5'($urandom); lsu_data_i = $urandom;
            end
            wb_stall_i    = ($urandom_range(0, 99) < 25);
            flush_i       = ($urandom_range(0, 99) < 3);
            issue_valid_i = ($urandom_range(0, 99) < 30);
            issue_frd_i   = 5'($urandom);
            set_q(5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
            step();
            if (g_f) fpu_valid_i = 1'b0;
            if (g_l) lsu_valid_i = 1'b0;
        end

        idle_inputs();
        repeat (12) step();
        chk("drain_exp_q", 64'(exp_q.size()), 64'd0);
        chk("drain_fifo", fifo_full_o, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
